// File: rtl/prga.sv
// ARC4 pseudo-random generation / decrypt stage: reads the KSA-prepared S box,
// produces the keystream and writes a length-prefixed plaintext from the ciphertext.
module prga #(
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned DW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [MEM_AW-1:0] s_addr,
  input  logic [DW-1:0]     s_rddata,
  output logic [DW-1:0]     s_wrdata,
  output logic              s_wren,
  output logic [MEM_AW-1:0] ct_addr,
  input  logic [DW-1:0]     ct_rddata,
  output logic [MEM_AW-1:0] pt_addr,
  output logic [DW-1:0]     pt_wrdata,
  output logic              pt_wren
);

  typedef enum logic [3:0] {
    IDLE,
    L_ADDR,
    L_DATA,
    W_LEN,
    I_ADDR,
    I_DATA,
    J_ADDR,
    J_DATA,
    W_I,
    W_J,
    P_ADDR,
    P_DATA,
    W_PT
  } state_e;

  state_e            state_q;
  logic              rdy_q;
  logic [MEM_AW-1:0] s_addr_q;
  logic [DW-1:0]     s_wrdata_q;
  logic              s_wren_q;
  logic [MEM_AW-1:0] ct_addr_q;
  logic [MEM_AW-1:0] pt_addr_q;
  logic [DW-1:0]     pt_wrdata_q;
  logic              pt_wren_q;
  logic [MEM_AW-1:0] i_q;
  logic [MEM_AW-1:0] j_q;
  logic [MEM_AW-1:0] k_q;
  logic [MEM_AW-1:0] len_q;
  logic [DW-1:0]     si_q;
  logic [DW-1:0]     sj_q;

  logic [MEM_AW-1:0] j_d;
  logic [MEM_AW-1:0] pad_addr_d;
  logic [MEM_AW-1:0] i_inc_d;
  logic [MEM_AW-1:0] k_inc_d;

  assign j_d        = j_q + MEM_AW'(s_rddata);
  assign pad_addr_d = MEM_AW'(si_q + sj_q);
  assign i_inc_d    = i_q + MEM_AW'(1);
  assign k_inc_d    = k_q + MEM_AW'(1);

  // Outputs are registered, so each state loads the values the next state presents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      len_q       <= '0;
      si_q        <= '0;
      sj_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q   <= L_ADDR;
            rdy_q     <= 1'b0;
            ct_addr_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
          end
        end
        L_ADDR: state_q <= L_DATA;
        L_DATA: begin
          len_q       <= MEM_AW'(ct_rddata);
          pt_addr_q   <= '0;
          pt_wrdata_q <= ct_rddata;
          pt_wren_q   <= 1'b1;
          state_q     <= W_LEN;
        end
        W_LEN: begin
          pt_wren_q <= 1'b0;
          k_q       <= MEM_AW'(1);
          i_q       <= MEM_AW'(1);
          if (len_q == '0) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end else begin
            s_addr_q <= MEM_AW'(1);
            state_q  <= I_ADDR;
          end
        end
        I_ADDR: state_q <= I_DATA;
        I_DATA: begin
          si_q     <= s_rddata;
          j_q      <= j_d;
          s_addr_q <= j_d;
          state_q  <= J_ADDR;
        end
        J_ADDR: state_q <= J_DATA;
        // Swap: write S[i]=sj then S[j]=si; identical when i==j.
        J_DATA: begin
          sj_q       <= s_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= s_rddata;
          s_wren_q   <= 1'b1;
          state_q    <= W_I;
        end
        W_I: begin
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          s_wren_q   <= 1'b1;
          state_q    <= W_J;
        end
        W_J: begin
          s_wren_q  <= 1'b0;
          s_addr_q  <= pad_addr_d;
          ct_addr_q <= k_q;
          state_q   <= P_ADDR;
        end
        P_ADDR: state_q <= P_DATA;
        P_DATA: begin
          pt_addr_q   <= k_q;
          pt_wrdata_q <= s_rddata ^ ct_rddata;
          pt_wren_q   <= 1'b1;
          state_q     <= W_PT;
        end
        W_PT: begin
          pt_wren_q <= 1'b0;
          if (k_q == len_q) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
          end else begin
            k_q      <= k_inc_d;
            i_q      <= i_inc_d;
            s_addr_q <= i_inc_d;
            state_q  <= I_ADDR;
          end
        end
        default: begin
          state_q   <= IDLE;
          rdy_q     <= 1'b1;
          s_wren_q  <= 1'b0;
          pt_wren_q <= 1'b0;
        end
      endcase
    end
  end

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

endmodule
